// File: rtl/load_align_unit.sv
// Sequential load path between the MEM stage and the data-memory port: issues one or two
// aligned bus reads per load and returns the lane-extracted, sign- or zero-extended result.
module load_align_unit #(
  parameter int DATA_W           = 32,
  parameter int ADDR_W           = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              req_valid_in,
  output logic              req_ready_out,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [1:0]        size_in,
  input  logic              signed_in,
  output logic              mem_req_valid_out,
  input  logic              mem_req_ready_in,
  output logic [ADDR_W-1:0] mem_addr_out,
  input  logic              mem_rdata_valid_in,
  input  logic [DATA_W-1:0] mem_rdata_in,
  output logic              rsp_valid_out,
  input  logic              rsp_ready_in,
  output logic [DATA_W-1:0] rsp_data_out,
  output logic              rsp_fault_out,
  output logic              rsp_split_out
);

  localparam int NB     = DATA_W / 8;
  localparam int LANE_W = $clog2(NB);
  localparam int CNT_W  = LANE_W + 2;

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

  state_t state_reg, state_next;

  logic [ADDR_W-1:0] addr_reg;
  logic [1:0]        size_reg;
  logic              signed_reg;
  logic              fault_reg;
  logic              split_reg;
  logic [DATA_W-1:0] lo_reg;
  logic [DATA_W-1:0] hi_reg;

  // Classify the incoming request: end_in is one past the last byte, relative to the beat.
  logic [LANE_W-1:0] lane_in;
  logic [CNT_W-1:0]  end_in;
  logic              illegal_in;
  logic              crossing_in;
  logic              fault_in;

  assign lane_in     = addr_in[LANE_W-1:0];
  assign end_in      = CNT_W'(lane_in) + (CNT_W'(1) << size_in);
  assign illegal_in  = (DATA_W == 32) && (size_in == 2'b11);
  assign crossing_in = end_in > CNT_W'(NB);
  assign fault_in    = illegal_in || (crossing_in && !ALLOW_MISALIGNED);

  logic [ADDR_W-1:0] base_addr;
  assign base_addr = {addr_reg[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      size_reg   <= '0;
      signed_reg <= 1'b0;
      fault_reg  <= 1'b0;
      split_reg  <= 1'b0;
      lo_reg     <= '0;
      hi_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && req_valid_in) begin
        addr_reg   <= addr_in;
        size_reg   <= size_in;
        signed_reg <= signed_in;
        fault_reg  <= fault_in;
        split_reg  <= crossing_in && !fault_in;
        lo_reg     <= '0;
        hi_reg     <= '0;
      end
      if (state_reg == WAIT0 && mem_rdata_valid_in) begin
        lo_reg <= mem_rdata_in;
      end
      if (state_reg == WAIT1 && mem_rdata_valid_in) begin
        hi_reg <= mem_rdata_in;
      end
    end
  end

  // Extraction over the two-beat window; hi_reg stays zero for single-beat loads.
  logic [2*DATA_W-1:0] window;
  logic [LANE_W+2:0]   shamt;
  logic [DATA_W-1:0]   shifted;
  logic [DATA_W-1:0]   extended;
  logic [6:0]          kept_bits;
  logic                sign_bit;

  assign window    = {hi_reg, lo_reg};
  assign shamt     = {addr_reg[LANE_W-1:0], 3'b000};
  assign shifted   = DATA_W'(window >> shamt);
  assign kept_bits = 7'd8 << size_reg;

  always_comb begin
    sign_bit = shifted[DATA_W-1];
    unique case (size_reg)
      2'b00:   sign_bit = shifted[7];
      2'b01:   sign_bit = shifted[15];
      2'b10:   sign_bit = shifted[31];
      default: sign_bit = shifted[DATA_W-1];
    endcase
  end

  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_ext
      assign extended[gi] = (7'(gi) < kept_bits) ? shifted[gi] : (signed_reg & sign_bit);
    end
  endgenerate

  always_comb begin
    state_next        = state_reg;
    req_ready_out     = 1'b0;
    mem_req_valid_out = 1'b0;
    mem_addr_out      = '0;
    rsp_valid_out     = 1'b0;
    rsp_data_out      = '0;
    rsp_fault_out     = 1'b0;
    rsp_split_out     = 1'b0;
    unique case (state_reg)
      IDLE: begin
        req_ready_out = 1'b1;
        if (req_valid_in) begin
          state_next = fault_in ? RESP : REQ0;
        end
      end
      REQ0: begin
        mem_req_valid_out = 1'b1;
        mem_addr_out      = base_addr;
        if (mem_req_ready_in) begin
          state_next = WAIT0;
        end
      end
      WAIT0: begin
        if (mem_rdata_valid_in) begin
          state_next = split_reg ? REQ1 : RESP;
        end
      end
      REQ1: begin
        mem_req_valid_out = 1'b1;
        mem_addr_out      = base_addr + ADDR_W'(NB);
        if (mem_req_ready_in) begin
          state_next = WAIT1;
        end
      end
      WAIT1: begin
        if (mem_rdata_valid_in) begin
          state_next = RESP;
        end
      end
      RESP: begin
        rsp_valid_out = 1'b1;
        rsp_data_out  = fault_reg ? '0 : extended;
        rsp_fault_out = fault_reg;
        rsp_split_out = split_reg;
        if (rsp_ready_in) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_align_unit.sv
// Bench for load_align_unit: three instances (32-bit split, 32-bit no-split, 64-bit) share one
// stimulus path selected by sel; results are checked against a byte-level memory model.
module tb_load_align_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] addr;
  logic [1:0]  size;
  logic        sgn;
  logic        mem_req_ready;
  logic        mem_rdata_valid;
  logic [63:0] mem_rdata;
  logic        rsp_ready;
  int          sel;

  int n_cmp;
  int n_err;

  always #5 clk = ~clk;

  logic        a_req_ready, a_mreq_valid, a_rsp_valid, a_fault, a_split;
  logic [31:0] a_maddr, a_rsp_data;
  logic        b_req_ready, b_mreq_valid, b_rsp_valid, b_fault, b_split;
  logic [31:0] b_maddr, b_rsp_data;
  logic        c_req_ready, c_mreq_valid, c_rsp_valid, c_fault, c_split;
  logic [31:0] c_maddr;
  logic [63:0] c_rsp_data;

  load_align_unit #(.DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) u_a (
    .clk_in(clk), .rst_in(rst),
    .req_valid_in(req_valid && sel == 0), .req_ready_out(a_req_ready),
    .addr_in(addr), .size_in(size), .signed_in(sgn),
    .mem_req_valid_out(a_mreq_valid), .mem_req_ready_in(mem_req_ready && sel == 0),
    .mem_addr_out(a_maddr),
    .mem_rdata_valid_in(mem_rdata_valid && sel == 0), .mem_rdata_in(mem_rdata[31:0]),
    .rsp_valid_out(a_rsp_valid), .rsp_ready_in(rsp_ready && sel == 0),
    .rsp_data_out(a_rsp_data), .rsp_fault_out(a_fault), .rsp_split_out(a_split)
  );

  load_align_unit #(.DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGNED(1'b0)) u_b (
    .clk_in(clk), .rst_in(rst),
    .req_valid_in(req_valid && sel == 1), .req_ready_out(b_req_ready),
    .addr_in(addr), .size_in(size), .signed_in(sgn),
    .mem_req_valid_out(b_mreq_valid), .mem_req_ready_in(mem_req_ready && sel == 1),
    .mem_addr_out(b_maddr),
    .mem_rdata_valid_in(mem_rdata_valid && sel == 1), .mem_rdata_in(mem_rdata[31:0]),
    .rsp_valid_out(b_rsp_valid), .rsp_ready_in(rsp_ready && sel == 1),
    .rsp_data_out(b_rsp_data), .rsp_fault_out(b_fault), .rsp_split_out(b_split)
  );

  load_align_unit #(.DATA_W(64), .ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) u_c (
    .clk_in(clk), .rst_in(rst),
    .req_valid_in(req_valid && sel == 2), .req_ready_out(c_req_ready),
    .addr_in(addr), .size_in(size), .signed_in(sgn),
    .mem_req_valid_out(c_mreq_valid), .mem_req_ready_in(mem_req_ready && sel == 2),
    .mem_addr_out(c_maddr),
    .mem_rdata_valid_in(mem_rdata_valid && sel == 2), .mem_rdata_in(mem_rdata),
    .rsp_valid_out(c_rsp_valid), .rsp_ready_in(rsp_ready && sel == 2),
    .rsp_data_out(c_rsp_data), .rsp_fault_out(c_fault), .rsp_split_out(c_split)
  );

  logic        o_req_ready, o_mreq_valid, o_rsp_valid, o_fault, o_split;
  logic [31:0] o_maddr;
  logic [63:0] o_rsp_data;

  always_comb begin
    o_req_ready  = a_req_ready;
    o_mreq_valid = a_mreq_valid;
    o_maddr      = a_maddr;
    o_rsp_valid  = a_rsp_valid;
    o_rsp_data   = {32'h0, a_rsp_data};
    o_fault      = a_fault;
    o_split      = a_split;
    if (sel == 1) begin
      o_req_ready  = b_req_ready;
      o_mreq_valid = b_mreq_valid;
      o_maddr      = b_maddr;
      o_rsp_valid  = b_rsp_valid;
      o_rsp_data   = {32'h0, b_rsp_data};
      o_fault      = b_fault;
      o_split      = b_split;
    end else if (sel == 2) begin
      o_req_ready  = c_req_ready;
      o_mreq_valid = c_mreq_valid;
      o_maddr      = c_maddr;
      o_rsp_valid  = c_rsp_valid;
      o_rsp_data   = c_rsp_data;
      o_fault      = c_fault;
      o_split      = c_split;
    end
  end

  // Byte-addressed memory: explicit overrides, otherwise a hash of the address.
  logic [7:0] mem_ovr [bit [31:0]];

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] h;
    if (mem_ovr.exists(a)) return mem_ovr[a];
    h = a * 32'h9E37_79B1;
    return h[31:24];
  endfunction

  function automatic logic [63:0] bus_word(input logic [31:0] a, input int nb);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < nb; i++) w[8*i +: 8] = mem_byte(a + 32'(i));
    return w;
  endfunction

  // Reference: gather the requested bytes little-endian, then extend to the bus width.
  function automatic logic [63:0] ref_data(input logic [31:0] a, input logic [1:0] sz,
                                           input logic sg, input int dw);
    int nbytes;
    logic [63:0] v;
    nbytes = 1 << sz;
    v = '0;
    for (int i = 0; i < nbytes; i++) v[8*i +: 8] = mem_byte(a + 32'(i));
    if (sg && v[8*nbytes-1]) for (int b = 8*nbytes; b < dw; b++) v[b] = 1'b1;
    return v;
  endfunction

  logic [31:0] r_addrs [$];
  logic [63:0] r_data;
  logic        r_fault, r_split;
  int          r_cycles;
  bit          r_timeout, r_stable, r_busy_ready, r_idle_ready;

  // Runs one load starting at the current negedge; returns at the negedge after the handshake.
  task automatic do_load(input int which, input logic [31:0] a, input logic [1:0] sz,
                         input logic sg, input bit rnd, input int hold_cycles);
    int nb, hold, pend_cnt;
    bit pend, got, done;
    logic [31:0] pend_addr;
    nb = (which == 2) ? 8 : 4;
    sel = which;
    r_addrs.delete();
    r_cycles = -1; r_timeout = 0; r_stable = 1; r_busy_ready = 0; r_idle_ready = 0;
    r_data = '0; r_fault = 0; r_split = 0;
    got = 0; done = 0; pend = 0; pend_cnt = 0; pend_addr = '0;
    hold = (hold_cycles >= 0) ? hold_cycles : (rnd ? int'($urandom_range(0, 3)) : 0);
    req_valid = 1; addr = a; size = sz; sgn = sg;
    mem_req_ready = 0; mem_rdata_valid = 0; rsp_ready = 0;
    for (int cyc = 1; cyc <= 100 && !done; cyc++) begin
      @(negedge clk);
      req_valid = 0; mem_req_ready = 0; mem_rdata_valid = 0; rsp_ready = 0;
      mem_rdata = {$urandom, $urandom};
      if (got && !o_rsp_valid) begin
        done = 1;
        r_idle_ready = o_req_ready;
      end else begin
        if (o_req_ready) r_busy_ready = 1;
        if (pend) begin
          if (pend_cnt == 0) begin
            mem_rdata_valid = 1;
            mem_rdata = bus_word(pend_addr, nb);
            pend = 0;
          end else begin
            pend_cnt--;
          end
        end
        if (rnd && !pend && !mem_rdata_valid && $urandom_range(0, 2) == 0) mem_rdata_valid = 1;
        if (o_mreq_valid) begin
          mem_req_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
          if (mem_req_ready) begin
            r_addrs.push_back(o_maddr);
            pend = 1;
            pend_addr = o_maddr;
            pend_cnt = rnd ? int'($urandom_range(0, 2)) : 0;
          end
        end
        if (o_rsp_valid) begin
          if (!got) begin
            got = 1; r_cycles = cyc;
            r_data = o_rsp_data; r_fault = o_fault; r_split = o_split;
          end else if (o_rsp_data !== r_data || o_fault !== r_fault || o_split !== r_split) begin
            r_stable = 0;
          end
          if (hold == 0) rsp_ready = 1;
          else hold--;
        end
      end
    end
    if (!done) begin
      r_timeout = 1;
      rst = 1;
      @(negedge clk);
      rst = 0;
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({a_req_ready, b_req_ready, c_req_ready} !== 3'b111) begin
      n_err++; $display("FAIL reset_req_ready: got %b required 111", {a_req_ready, b_req_ready, c_req_ready});
    end
    n_cmp++;
    if ({a_mreq_valid, b_mreq_valid, c_mreq_valid, a_rsp_valid, b_rsp_valid, c_rsp_valid} !== 6'b0) begin
      n_err++; $display("FAIL reset_valids: got %b required 000000",
                        {a_mreq_valid, b_mreq_valid, c_mreq_valid, a_rsp_valid, b_rsp_valid, c_rsp_valid});
    end
    n_cmp++;
    if ({a_maddr, c_maddr, a_rsp_data, c_rsp_data, a_fault, a_split, c_fault, c_split} !== '0) begin
      n_err++; $display("FAIL reset_data: addr %h/%h data %h/%h not zero", a_maddr, c_maddr, a_rsp_data, c_rsp_data);
    end
    rst = 0;
    @(negedge clk);
    n_cmp++;
    if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL post_reset_idle: ready %b valid %b required 1 0", a_req_ready, a_rsp_valid);
    end
  endtask

  typedef struct {
    int which; logic [31:0] a; logic [1:0] sz; logic sg;
    logic [63:0] d; logic f; logic s; int n; logic [31:0] a0; logic [31:0] a1; int cyc;
  } dcase_t;

  task automatic test_directed();
    dcase_t dc [11];
    mem_ovr[32'h1000] = 8'h34; mem_ovr[32'h1001] = 8'h12;
    mem_ovr[32'h1002] = 8'hFF; mem_ovr[32'h1003] = 8'h80;
    mem_ovr[32'h2003] = 8'h44;
    mem_ovr[32'h2004] = 8'h33; mem_ovr[32'h2005] = 8'h22;
    mem_ovr[32'h2006] = 8'h11; mem_ovr[32'h2007] = 8'h00;
    mem_ovr[32'h8] = 8'h01;
    for (int i = 9; i < 15; i++) mem_ovr[32'(i)] = 8'h00;
    mem_ovr[32'hF] = 8'h80;
    dc[0]  = '{0, 32'h1002, 2'd0, 1'b1, 64'hFFFF_FFFF, 1'b0, 1'b0, 1, 32'h1000, 32'h0, 3};
    dc[1]  = '{0, 32'h1002, 2'd1, 1'b0, 64'h0000_80FF, 1'b0, 1'b0, 1, 32'h1000, 32'h0, 3};
    dc[2]  = '{0, 32'h1002, 2'd1, 1'b1, 64'hFFFF_80FF, 1'b0, 1'b0, 1, 32'h1000, 32'h0, 3};
    dc[3]  = '{0, 32'h2003, 2'd2, 1'b0, 64'h1122_3344, 1'b0, 1'b1, 2, 32'h2000, 32'h2004, 5};
    dc[4]  = '{0, 32'hFFFF_FFFE, 2'd2, 1'b0, ref_data(32'hFFFF_FFFE, 2'd2, 1'b0, 32),
               1'b0, 1'b1, 2, 32'hFFFF_FFFC, 32'h0, 5};
    dc[5]  = '{1, 32'h2003, 2'd2, 1'b0, 64'h0, 1'b1, 1'b0, 0, 32'h0, 32'h0, 1};
    dc[6]  = '{0, 32'h1000, 2'd3, 1'b0, 64'h0, 1'b1, 1'b0, 0, 32'h0, 32'h0, 1};
    dc[7]  = '{2, 32'h8, 2'd3, 1'b1, 64'h8000_0000_0000_0001, 1'b0, 1'b0, 1, 32'h8, 32'h0, 3};
    dc[8]  = '{1, 32'h2004, 2'd2, 1'b1, 64'h0011_2233, 1'b0, 1'b0, 1, 32'h2004, 32'h0, 3};
    dc[9]  = '{2, 32'h2003, 2'd2, 1'b1, 64'h1122_3344, 1'b0, 1'b0, 1, 32'h2000, 32'h0, 3};
    dc[10] = '{2, 32'h2006, 2'd2, 1'b0, ref_data(32'h2006, 2'd2, 1'b0, 64),
               1'b0, 1'b1, 2, 32'h2000, 32'h2008, 5};
    foreach (dc[i]) begin
      do_load(dc[i].which, dc[i].a, dc[i].sz, dc[i].sg, 1'b0, 0);
      $display("directed %0d: dut %0d addr %h size %0d -> data %h fault %b split %b cycles %0d",
               i, dc[i].which, dc[i].a, dc[i].sz, r_data, r_fault, r_split, r_cycles);
      n_cmp++;
      if (r_timeout) begin n_err++; $display("FAIL dir%0d_timeout: no response", i); end
      n_cmp++;
      if (r_data !== dc[i].d) begin n_err++; $display("FAIL dir%0d_data: got %h required %h", i, r_data, dc[i].d); end
      n_cmp++;
      if ({r_fault, r_split} !== {dc[i].f, dc[i].s}) begin
        n_err++; $display("FAIL dir%0d_flags: got f%b s%b required f%b s%b", i, r_fault, r_split, dc[i].f, dc[i].s);
      end
      n_cmp++;
      if (r_addrs.size() != dc[i].n) begin
        n_err++; $display("FAIL dir%0d_nreq: got %0d bus requests required %0d", i, r_addrs.size(), dc[i].n);
      end
      if (dc[i].n >= 1 && r_addrs.size() >= 1) begin
        n_cmp++;
        if (r_addrs[0] !== dc[i].a0) begin n_err++; $display("FAIL dir%0d_addr0: got %h required %h", i, r_addrs[0], dc[i].a0); end
      end
      if (dc[i].n >= 2 && r_addrs.size() >= 2) begin
        n_cmp++;
        if (r_addrs[1] !== dc[i].a1) begin n_err++; $display("FAIL dir%0d_addr1: got %h required %h", i, r_addrs[1], dc[i].a1); end
      end
      n_cmp++;
      if (r_cycles != dc[i].cyc) begin n_err++; $display("FAIL dir%0d_latency: got %0d required %0d", i, r_cycles, dc[i].cyc); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    for (int i = 0; i < 6; i++) begin
      a = 32'h4000 + 32'($urandom_range(0, 63));
      do_load(0, a, 2'd1, 1'b1, 1'b0, 0);
      $display("b2b %0d: addr %h -> data %h cycles %0d idle_ready %b", i, a, r_data, r_cycles, r_idle_ready);
      n_cmp++;
      if (r_data !== ref_data(a, 2'd1, 1'b1, 32)) begin
        n_err++; $display("FAIL b2b_data: got %h required %h", r_data, ref_data(a, 2'd1, 1'b1, 32));
      end
      n_cmp++;
      if (r_cycles != ((a[1:0] == 2'd3) ? 5 : 3)) begin
        n_err++; $display("FAIL b2b_latency: got %0d required %0d", r_cycles, (a[1:0] == 2'd3) ? 5 : 3);
      end
      n_cmp++;
      if (r_idle_ready !== 1'b1 || r_busy_ready !== 1'b0) begin
        n_err++; $display("FAIL b2b_ready: idle %b busy %b required 1 0", r_idle_ready, r_busy_ready);
      end
    end
  endtask

  task automatic test_stall();
    do_load(0, 32'h2003, 2'd2, 1'b0, 1'b0, 25);
    $display("stall: data %h split %b stable %b", r_data, r_split, r_stable);
    n_cmp++;
    if (r_stable !== 1'b1) begin n_err++; $display("FAIL stall_stable: got %b required 1", r_stable); end
    n_cmp++;
    if (r_data !== 64'h1122_3344 || r_split !== 1'b1) begin
      n_err++; $display("FAIL stall_data: got %h s%b required 1122_3344 s1", r_data, r_split);
    end
  endtask

  task automatic test_reset_midop();
    sel = 0; mem_req_ready = 0; mem_rdata_valid = 0; rsp_ready = 0;
    // Reset while stalled in REQ0.
    req_valid = 1; addr = 32'h3000; size = 2'd2; sgn = 0;
    @(negedge clk);
    req_valid = 0;
    n_cmp++;
    if (a_mreq_valid !== 1'b1) begin n_err++; $display("FAIL rst_req0_pre: mem_req_valid %b required 1", a_mreq_valid); end
    #2 rst = 1;
    #1;
    n_cmp++;
    if (a_mreq_valid !== 1'b0 || a_req_ready !== 1'b1) begin
      n_err++; $display("FAIL rst_req0_drop: mem_req_valid %b ready %b required 0 1", a_mreq_valid, a_req_ready);
    end
    @(negedge clk);
    rst = 0;
    // Reset while stalled in RESP with a fault.
    req_valid = 1; addr = 32'h3000; size = 2'd3;
    @(negedge clk);
    req_valid = 0;
    #2 rst = 1;
    #1;
    n_cmp++;
    if (a_rsp_valid !== 1'b0 || a_fault !== 1'b0) begin
      n_err++; $display("FAIL rst_resp_drop: rsp_valid %b fault %b required 0 0", a_rsp_valid, a_fault);
    end
    @(negedge clk);
    rst = 0;
    // Split load driven into WAIT1, then reset before the second beat.
    req_valid = 1; addr = 32'h2003; size = 2'd2;
    @(negedge clk);
    req_valid = 0; mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0; mem_rdata_valid = 1; mem_rdata = bus_word(32'h2000, 4);
    @(negedge clk);
    mem_rdata_valid = 0; mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0;
    #2 rst = 1;
    #1;
    n_cmp++;
    if ({a_mreq_valid, a_rsp_valid, a_req_ready} !== 3'b001) begin
      n_err++; $display("FAIL rst_wait1: valids %b%b ready %b required 0 0 1", a_mreq_valid, a_rsp_valid, a_req_ready);
    end
    @(negedge clk);
    rst = 0;
    mem_rdata_valid = 1; mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1) begin
        n_err++; $display("FAIL rst_stale_beat: rsp_valid %b ready %b required 0 1", a_rsp_valid, a_req_ready);
      end
    end
    mem_rdata_valid = 0;
    do_load(0, 32'h1000, 2'd2, 1'b0, 1'b0, 0);
    $display("post-reset load: data %h cycles %0d", r_data, r_cycles);
    n_cmp++;
    if (r_data !== 64'h80FF_1234 || r_cycles != 3) begin
      n_err++; $display("FAIL rst_recover: got %h cycles %0d required 80ff1234 cycles 3", r_data, r_cycles);
    end
  endtask

  task automatic test_random();
    int which, nb, lane, nbytes, exp_n;
    logic [31:0] a, base;
    logic [1:0] sz;
    logic sg, exp_f, exp_s;
    logic [63:0] exp_d;
    bit addr_ok;
    for (int i = 0; i < 200; i++) begin
      which = $urandom_range(0, 2);
      a = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      nb = (which == 2) ? 8 : 4;
      lane = int'(a % 32'(nb));
      nbytes = 1 << sz;
      exp_f = (sz == 2'd3 && nb == 4) || (which == 1 && lane + nbytes > nb);
      exp_s = !exp_f && (lane + nbytes > nb);
      exp_d = exp_f ? 64'h0 : ref_data(a, sz, sg, nb * 8);
      exp_n = exp_f ? 0 : (exp_s ? 2 : 1);
      base = a & ~32'(nb - 1);
      do_load(which, a, sz, sg, 1'b1, -1);
      $display("random %0d: dut %0d addr %h size %0d signed %b -> data %h f%b s%b",
               i, which, a, sz, sg, r_data, r_fault, r_split);
      n_cmp++;
      if (r_timeout) begin n_err++; $display("FAIL rnd%0d_timeout: no response", i); end
      n_cmp++;
      if (r_data !== exp_d) begin n_err++; $display("FAIL rnd%0d_data: got %h required %h", i, r_data, exp_d); end
      n_cmp++;
      if ({r_fault, r_split} !== {exp_f, exp_s}) begin
        n_err++; $display("FAIL rnd%0d_flags: got f%b s%b required f%b s%b", i, r_fault, r_split, exp_f, exp_s);
      end
      addr_ok = (r_addrs.size() == exp_n) && (exp_n < 1 || r_addrs[0] == base)
                && (exp_n < 2 || r_addrs[1] == base + 32'(nb));
      n_cmp++;
      if (!addr_ok) begin
        n_err++; $display("FAIL rnd%0d_bus: got %0d requests required %0d at %h", i, r_addrs.size(), exp_n, base);
      end
      n_cmp++;
      if (r_stable !== 1'b1 || r_busy_ready !== 1'b0 || r_idle_ready !== 1'b1) begin
        n_err++; $display("FAIL rnd%0d_handshake: stable %b busy_ready %b idle_ready %b required 1 0 1",
                          i, r_stable, r_busy_ready, r_idle_ready);
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; sel = 0;
    req_valid = 0; addr = '0; size = '0; sgn = 0;
    mem_req_ready = 0; mem_rdata_valid = 0; mem_rdata = '0; rsp_ready = 0;
    rst = 1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_midop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
